// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush control with load-use, branch, jump and memory-wait handling.
// Define HAZARD_STATS_EN to build the saturating Stall_Cycles/Flush_Count statistics counters.
module hazard_unit #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IFID_Reg_Rs,
    input  logic [4:0]  IFID_Reg_Rt,
    input  logic [4:0]  IDEX_Reg_Rt,
    input  logic        IDEX_MemRead,
    input  logic        ID_Jump,
    input  logic        EX_Branch_Taken,
    input  logic        MEM_Req,
    input  logic        MEM_Ready,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IDEX_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        EXMEM_Hold,
    output logic [1:0]  Hazard_State,
    output logic        Mem_Timeout,
    output logic [15:0] Stall_Cycles,
    output logic [15:0] Flush_Count
);
    localparam logic [1:0] RUN       = 2'b00;
    localparam logic [1:0] LU_BUBBLE = 2'b01;
    localparam logic [1:0] MEM_WAIT  = 2'b10;
    localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);

    logic [1:0] state, next_state;
    logic [7:0] wait_cnt, wait_nxt;
    logic       mem_stall, load_use;

    assign mem_stall = MEM_Req && !MEM_Ready;
    // The bubble is already in EX while in LU_BUBBLE, so a still-matching load must not stall again.
    assign load_use  = IDEX_MemRead && IDEX_Reg_Rt != 5'd0 && state != LU_BUBBLE &&
                       (IDEX_Reg_Rt == IFID_Reg_Rs || IDEX_Reg_Rt == IFID_Reg_Rt);
    assign Hazard_State = state;

    always_comb begin
        PC_Write   = 1'b1;
        IFID_Write = 1'b1;
        IDEX_Write = 1'b1;
        IFID_Flush = 1'b0;
        IDEX_Flush = 1'b0;
        EXMEM_Hold = 1'b0;
        next_state = RUN;
        if (reset) begin
            if (mem_stall) begin
                PC_Write   = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Write = 1'b0;
                EXMEM_Hold = 1'b1;
                next_state = MEM_WAIT;
            end else if (EX_Branch_Taken) begin
                IFID_Flush = 1'b1;
                IDEX_Flush = 1'b1;
            end else if (load_use) begin
                PC_Write   = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Flush = 1'b1;
                next_state = LU_BUBBLE;
            end else if (ID_Jump) begin
                IFID_Flush = 1'b1;
            end
        end
    end

    assign wait_nxt = next_state != MEM_WAIT ? 8'd0 : wait_cnt == 8'hFF ? wait_cnt : wait_cnt + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            Mem_Timeout <= 1'b0;
        end else begin
            state       <= next_state;
            wait_cnt    <= wait_nxt;
            Mem_Timeout <= Mem_Timeout || (next_state == MEM_WAIT && wait_nxt == TIMEOUT);
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Stall_Cycles <= 16'h0000;
            Flush_Count  <= 16'h0000;
        end else begin
            if (!PC_Write && Stall_Cycles != 16'hFFFF)
                Stall_Cycles <= Stall_Cycles + 16'd1;
            if ((IFID_Flush || IDEX_Flush) && Flush_Count != 16'hFFFF)
                Flush_Count <= Flush_Count + 16'd1;
        end
    end
`else
    assign Stall_Cycles = 16'h0000;
    assign Flush_Count  = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed-vector bench for hazard_unit, built with MEM_TIMEOUT=4.
module tb_hazard_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs, rt, idrt;
    logic        mr, jmp, br, req, rdy;
    logic        pc_w, ifid_w, idex_w, ifid_f, idex_f, hold, tmo;
    logic [1:0]  st;
    logic [15:0] stall_cyc, flush_cnt;
    logic [5:0]  ctl;
    int          n_cmp = 0;
    int          n_bad = 0;

`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    hazard_unit #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .IFID_Reg_Rs(rs), .IFID_Reg_Rt(rt), .IDEX_Reg_Rt(idrt), .IDEX_MemRead(mr),
        .ID_Jump(jmp), .EX_Branch_Taken(br), .MEM_Req(req), .MEM_Ready(rdy),
        .PC_Write(pc_w), .IFID_Write(ifid_w), .IDEX_Write(idex_w),
        .IFID_Flush(ifid_f), .IDEX_Flush(idex_f), .EXMEM_Hold(hold),
        .Hazard_State(st), .Mem_Timeout(tmo),
        .Stall_Cycles(stall_cyc), .Flush_Count(flush_cnt)
    );

    always #5 clk = ~clk;
    assign ctl = {pc_w, ifid_w, idex_w, ifid_f, idex_f, hold};

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic [4:0] a_rs, a_rt, a_idrt, input logic a_mr, a_jmp, a_br, a_req, a_rdy);
        @(posedge clk);
        #1;
        rs = a_rs; rt = a_rt; idrt = a_idrt; mr = a_mr;
        jmp = a_jmp; br = a_br; req = a_req; rdy = a_rdy;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        rs = 0; rt = 0; idrt = 0; mr = 0; jmp = 0; br = 0; req = 1'b1; rdy = 1'b0;
        #3;
        chk("rst_ctl", 16'(ctl), 16'b111000);
        chk("rst_state", 16'(st), 16'd0);
        chk("rst_tmo", 16'(tmo), 16'd0);
        chk("rst_stall", stall_cyc, 16'd0);
        chk("rst_flush", flush_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        req = 1'b0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle_ctl", 16'(ctl), 16'b111000);
        chk("idle_state", 16'(st), 16'd0);
        cyc(5, 0, 5, 1, 0, 0, 0, 0);
        chk("lu_rs_ctl", 16'(ctl), 16'b001010);
        chk("lu_rs_state", 16'(st), 16'd0);
        cyc(5, 0, 5, 1, 0, 0, 0, 0);
        chk("lu_bubble_state", 16'(st), 16'd1);
        chk("lu_bubble_ctl", 16'(ctl), 16'b111000);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_back_state", 16'(st), 16'd0);
        chk("lu_back_ctl", 16'(ctl), 16'b111000);
        cyc(0, 7, 7, 1, 0, 0, 0, 0);
        chk("lu_rt_ctl", 16'(ctl), 16'b001010);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_rt_state", 16'(st), 16'd1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("r0_ctl", 16'(ctl), 16'b111000);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("r0_state", 16'(st), 16'd0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        chk("jump_ctl", 16'(ctl), 16'b111100);
        cyc(5, 0, 5, 1, 0, 1, 0, 0);
        chk("br_lu_ctl", 16'(ctl), 16'b111110);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_lu_state", 16'(st), 16'd0);

        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("ms1_ctl", 16'(ctl), 16'b000001);
        chk("ms1_state", 16'(st), 16'd0);
        cyc(5, 0, 5, 1, 0, 0, 1, 0);
        chk("ms2_lu_ctl", 16'(ctl), 16'b000001);
        chk("ms2_state", 16'(st), 16'd2);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("ms3_ctl", 16'(ctl), 16'b000001);
        chk("ms3_state", 16'(st), 16'd2);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("ms_rel_ctl", 16'(ctl), 16'b111000);
        chk("ms_rel_state", 16'(st), 16'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ms_run_state", 16'(st), 16'd0);
        chk("ms_tmo", 16'(tmo), 16'd0);
        chk("stat_stall_a", stall_cyc, STATS ? 16'd5 : 16'd0);
        chk("stat_flush_a", flush_cnt, STATS ? 16'd4 : 16'd0);

        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("to_w1_tmo", 16'(tmo), 16'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("to_w3_tmo", 16'(tmo), 16'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("to_w4_tmo", 16'(tmo), 16'd1);
        chk("to_w4_state", 16'(st), 16'd2);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("to_rel_state", 16'(st), 16'd2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("to_run_state", 16'(st), 16'd0);
        chk("to_sticky", 16'(tmo), 16'd1);
        chk("stat_stall_b", stall_cyc, STATS ? 16'd10 : 16'd0);

        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("rw_state", 16'(st), 16'd2);
        #2 reset = 1'b0;
        #1;
        chk("rw_rst_state", 16'(st), 16'd0);
        chk("rw_rst_tmo", 16'(tmo), 16'd0);
        chk("rw_rst_ctl", 16'(ctl), 16'b111000);
        chk("rw_rst_stall", stall_cyc, 16'd0);
        chk("rw_rst_flush", flush_cnt, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        req = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_state", 16'(st), 16'd0);
        chk("post_rst_ctl", 16'(ctl), 16'b111000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
